commit_trace_filter: RTL and testbench

- Sits directly downstream of the commit stage, next to the instruction-tracer decode definitions.
- Classifies each committed instruction as load, store, encrypted load (LENC), encrypted store (SENC), control-transfer, system/CSR or other.
- Filters instructions by a per-class enable mask and buffers the survivors in a small FIFO.
- Drains entries to a trace sink over a valid/ready handshake, and counts entries lost to overflow.

---
 rtl/commit_trace_filter.sv | 205 ++++++++++++++++++++
 tb/tb_commit_trace_filter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_filter.sv
// commit_trace_filter: classifies committed instructions, keeps the classes
// enabled in class_mask_i, buffers them in a small FIFO and drains them to a
// trace sink. Entries that arrive while the FIFO is full are counted as drops.
module commit_trace_filter #(
   parameter int VLEN     = 64,
   parameter int Depth    = 8,
   parameter int SeqWidth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       commit_valid_i,
   input  logic [VLEN-1:0]            commit_pc_i,
   input  logic [31:0]                commit_instr_i,
   input  logic                       commit_is_compressed_i,
   input  logic [VLEN-1:0]            commit_mem_addr_i,
   input  logic [7:0]                 class_mask_i,
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic [VLEN-1:0]            trace_pc_o,
   output logic [31:0]                trace_instr_o,
   output logic [2:0]                 trace_class_o,
   output logic [VLEN-1:0]            trace_addr_o,
   output logic [SeqWidth-1:0]        trace_seq_o,
   output logic [$clog2(Depth):0]     fifo_count_o,
   output logic [15:0]                drop_count_o,
   output logic                       overflow_o
);

   localparam int PW = $clog2(Depth);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

   localparam logic [2:0] CLS_OTHER = 3'd0;
   localparam logic [2:0] CLS_LOAD  = 3'd1;
   localparam logic [2:0] CLS_STORE = 3'd2;
   localparam logic [2:0] CLS_LENC  = 3'd3;
   localparam logic [2:0] CLS_SENC  = 3'd4;
   localparam logic [2:0] CLS_CTRL  = 3'd5;
   localparam logic [2:0] CLS_SYS   = 3'd6;

   typedef struct packed {
      logic [VLEN-1:0]     pc;
      logic [31:0]         instr;
      logic [2:0]          cls;
      logic [VLEN-1:0]     addr;
      logic [SeqWidth-1:0] seq;
   } entry_t;

   entry_t              mem_q [Depth];
   entry_t              head_q, head_d;
   entry_t              push_entry;
   logic                valid_q, valid_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [15:0]         drop_q, drop_d;
   logic                ovf_q, ovf_d;
   logic [SeqWidth-1:0] seq_q, seq_d;

   logic [2:0]          commit_cls;
   logic                push_req, pop, full, wr_en, rd_en, drop;
   logic                is_mem_cls;

   // Decode the committed instruction into its trace class
   always_comb begin
      commit_cls = CLS_OTHER;
      if (commit_is_compressed_i) begin
         case (commit_instr_i[1:0])
            2'b00: begin
               case (commit_instr_i[15:13])
                  3'b001, 3'b010, 3'b011: commit_cls = CLS_LOAD;
                  3'b101, 3'b110, 3'b111: commit_cls = CLS_STORE;
                  default:                commit_cls = CLS_OTHER;
               endcase
            end
            2'b01: begin
               case (commit_instr_i[15:13])
                  3'b101, 3'b110, 3'b111: commit_cls = CLS_CTRL;
                  default:                commit_cls = CLS_OTHER;
               endcase
            end
            2'b10: begin
               case (commit_instr_i[15:13])
                  3'b001, 3'b010, 3'b011: commit_cls = CLS_LOAD;
                  3'b101, 3'b110, 3'b111: commit_cls = CLS_STORE;
                  3'b100: begin
                     // C.EBREAK is the single system encoding; JR/JALR have rs2=0, rs1!=0
                     if (commit_instr_i[15:0] == 16'h9002)
                        commit_cls = CLS_SYS;
                     else if (commit_instr_i[6:2] == 5'd0 && commit_instr_i[11:7] != 5'd0)
                        commit_cls = CLS_CTRL;
                     else
                        commit_cls = CLS_OTHER;
                  end
                  default: commit_cls = CLS_OTHER;
               endcase
            end
            default: commit_cls = CLS_OTHER;
         endcase
      end else begin
         case (commit_instr_i[6:0])
            7'b0000011: commit_cls = (commit_instr_i[14:12] == 3'b111) ? CLS_LENC : CLS_LOAD;
            7'b0100011: commit_cls = (commit_instr_i[14:12] == 3'b111) ? CLS_SENC : CLS_STORE;
            7'b0000111: commit_cls = CLS_LOAD;
            7'b0100111: commit_cls = CLS_STORE;
            7'b1100011, 7'b1101111, 7'b1100111: commit_cls = CLS_CTRL;
            7'b1110011: commit_cls = CLS_SYS;
            default:    commit_cls = CLS_OTHER;
         endcase
      end
   end

   // Build the candidate entry and the push/pop/drop decisions
   always_comb begin
      is_mem_cls       = (commit_cls >= CLS_LOAD) && (commit_cls <= CLS_SENC);
      push_entry.pc    = commit_pc_i;
      push_entry.instr = commit_instr_i;
      push_entry.cls   = commit_cls;
      push_entry.addr  = is_mem_cls ? commit_mem_addr_i : '0;
      push_entry.seq   = seq_q;

      push_req = commit_valid_i & class_mask_i[commit_cls];
      pop      = valid_q & trace_ready_i;
      full     = (count_q == FULL_CNT);
      // A flush discards any push or pop presented in the same cycle
      wr_en    = push_req & (~full | pop) & ~flush_i;
      rd_en    = pop & ~flush_i;
      drop     = push_req & full & ~pop & ~flush_i;
   end

   // Next-state for pointers, occupancy, drop accounting, sequence and head
   always_comb begin
      seq_d    = commit_valid_i ? seq_q + SeqWidth'(1) : seq_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      head_d   = head_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(wr_en) - CW'(rd_en);
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end
      end
      valid_d = (count_d != '0);
      // Head register tracks the next oldest entry; bypass when it is being written now.
      // With the FIFO empty the head keeps its last contents.
      if (valid_d) begin
         if (wr_en && (wr_ptr_q == rd_ptr_d))
            head_d = push_entry;
         else
            head_d = mem_q[rd_ptr_d];
      end
   end

   // Control and head registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         seq_q    <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         seq_q    <= seq_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   // Entry storage; left unreset so it can map onto RAM
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_entry;
   end

   assign trace_valid_o = valid_q;
   assign trace_pc_o    = head_q.pc;
   assign trace_instr_o = head_q.instr;
   assign trace_class_o = head_q.cls;
   assign trace_addr_o  = head_q.addr;
   assign trace_seq_o   = head_q.seq;
   assign fifo_count_o  = count_q;
   assign drop_count_o  = drop_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_commit_trace_filter.sv
// Directed bench for commit_trace_filter with a queue scoreboard of expected entries.
module tb_commit_trace_filter;

   localparam int DEPTH = 8;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [2:0]  cls;
      logic [63:0] addr;
      logic [15:0] seq;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        commit_valid_i = 1'b0;
   logic [63:0] commit_pc_i = '0;
   logic [31:0] commit_instr_i = '0;
   logic        commit_is_compressed_i = 1'b0;
   logic [63:0] commit_mem_addr_i = '0;
   logic [7:0]  class_mask_i = 8'hFF;
   logic        trace_valid_o;
   logic        trace_ready_i = 1'b0;
   logic [63:0] trace_pc_o;
   logic [31:0] trace_instr_o;
   logic [2:0]  trace_class_o;
   logic [63:0] trace_addr_o;
   logic [15:0] trace_seq_o;
   logic [3:0]  fifo_count_o;
   logic [15:0] drop_count_o;
   logic        overflow_o;

   commit_trace_filter dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .flush_i                (flush_i),
      .commit_valid_i         (commit_valid_i),
      .commit_pc_i            (commit_pc_i),
      .commit_instr_i         (commit_instr_i),
      .commit_is_compressed_i (commit_is_compressed_i),
      .commit_mem_addr_i      (commit_mem_addr_i),
      .class_mask_i           (class_mask_i),
      .trace_valid_o          (trace_valid_o),
      .trace_ready_i          (trace_ready_i),
      .trace_pc_o             (trace_pc_o),
      .trace_instr_o          (trace_instr_o),
      .trace_class_o          (trace_class_o),
      .trace_addr_o           (trace_addr_o),
      .trace_seq_o            (trace_seq_o),
      .fifo_count_o           (fifo_count_o),
      .drop_count_o           (drop_count_o),
      .overflow_o             (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_assert = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   logic [15:0] m_seq  = '0;
   logic [15:0] m_drop = '0;
   logic        m_ovf  = 1'b0;
   logic [63:0] pc_m   = 64'h0000_0000_1000_0000;
   logic [63:0] cur_addr = 64'h0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: compare head, update model, advance, compare status
   task automatic step(input logic cv, input logic [31:0] ins, input logic comp,
                       input logic [2:0] ecls, input logic rdy, input logic fl);
      exp_t e;
      bit   pop_m, full_m;
      commit_valid_i         = cv;
      commit_instr_i         = ins;
      commit_is_compressed_i = comp;
      commit_pc_i            = pc_m;
      commit_mem_addr_i      = cur_addr;
      trace_ready_i          = rdy;
      flush_i                = fl;
      chk("valid", {63'd0, trace_valid_o}, {63'd0, sb.size() != 0});
      if (sb.size() != 0) begin
         chk("pc", trace_pc_o, sb[0].pc);
         chk("instr", {32'd0, trace_instr_o}, {32'd0, sb[0].instr});
         chk("class", {61'd0, trace_class_o}, {61'd0, sb[0].cls});
         chk("addr", trace_addr_o, sb[0].addr);
         chk("seq", {48'd0, trace_seq_o}, {48'd0, sb[0].seq});
      end
      pop_m  = rdy && (sb.size() != 0);
      full_m = (sb.size() == DEPTH);
      if (fl) begin
         sb.delete();
         m_drop = '0;
         m_ovf  = 1'b0;
      end else begin
         if (pop_m) void'(sb.pop_front());
         if (cv && class_mask_i[ecls]) begin
            if (full_m && !pop_m) begin
               if (m_drop != 16'hFFFF) m_drop++;
               m_ovf = 1'b1;
            end else begin
               e.pc    = pc_m;
               e.instr = ins;
               e.cls   = ecls;
               e.addr  = (ecls >= 3'd1 && ecls <= 3'd4) ? cur_addr : 64'd0;
               e.seq   = m_seq;
               sb.push_back(e);
            end
         end
      end
      if (cv) m_seq++;
      pc_m += 64'd4;
      @(posedge clk_i);
      #1;
      commit_valid_i = 1'b0;
      flush_i        = 1'b0;
      chk("count", {60'd0, fifo_count_o}, 64'(sb.size()));
      chk("drop", {48'd0, drop_count_o}, {48'd0, m_drop});
      chk("ovf", {63'd0, overflow_o}, {63'd0, m_ovf});
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 4 && sb.size() != 0; i++)
         step(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("drained", {60'd0, fifo_count_o}, 64'd0);
   endtask

   // Reset with a commit and ready presented, so reset must win over both
   task automatic do_reset();
      rst_i          = 1'b1;
      commit_valid_i = 1'b1;
      commit_instr_i = 32'h0000_A103;
      trace_ready_i  = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i          = 1'b0;
      commit_valid_i = 1'b0;
      trace_ready_i  = 1'b0;
      sb.delete();
      m_seq  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
      chk("rst_valid", {63'd0, trace_valid_o}, 64'd0);
      chk("rst_count", {60'd0, fifo_count_o}, 64'd0);
      chk("rst_drop", {48'd0, drop_count_o}, 64'd0);
      chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
      chk("rst_pc", trace_pc_o, 64'd0);
      chk("rst_instr", {32'd0, trace_instr_o}, 64'd0);
      chk("rst_class", {61'd0, trace_class_o}, 64'd0);
      chk("rst_addr", trace_addr_o, 64'd0);
      chk("rst_seq", {48'd0, trace_seq_o}, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk_i);
      #1;
      do_reset();

      // LENC / SENC classification
      class_mask_i = 8'hFF;
      cur_addr = 64'h0000_0000_8000_0040;
      step(1'b1, 32'h0000_7503, 1'b0, 3'd3, 1'b0, 1'b0);
      step(1'b1, 32'h00A5_7023, 1'b0, 3'd4, 1'b0, 1'b0);
      drain();

      // Filtering: loads only
      do_reset();
      class_mask_i = 8'h02;
      cur_addr = 64'h0000_0000_0000_2000;
      step(1'b1, 32'h0010_0093, 1'b0, 3'd0, 1'b0, 1'b0);
      chk("filter_count0", {60'd0, fifo_count_o}, 64'd0);
      step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b0, 1'b0);
      chk("filter_count1", {60'd0, fifo_count_o}, 64'd1);
      chk("filter_seq", {48'd0, trace_seq_o}, 64'd1);
      drain();

      // Overflow: 10 back-to-back commits into a stalled sink
      do_reset();
      class_mask_i = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         cur_addr = 64'h0000_0000_9000_0000 + 64'(i * 8);
         step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b0, 1'b0);
      end
      chk("ovf_count", {60'd0, fifo_count_o}, 64'd8);
      chk("ovf_drop", {48'd0, drop_count_o}, 64'd2);
      chk("ovf_flag", {63'd0, overflow_o}, 64'd1);
      // Full with simultaneous push and pop: new entry delivered last
      cur_addr = 64'h0000_0000_A000_0000;
      step(1'b1, 32'h0000_A023, 1'b0, 3'd2, 1'b1, 1'b0);
      chk("fullpp_count", {60'd0, fifo_count_o}, 64'd8);
      chk("fullpp_drop", {48'd0, drop_count_o}, 64'd2);
      drain();

      // Compressed and assorted uncompressed classes, non-memory addr forced to 0
      cur_addr = 64'h0000_0000_C000_0010;
      step(1'b1, 32'h0000_9002, 1'b1, 3'd6, 1'b0, 1'b0);
      step(1'b1, 32'h0000_8082, 1'b1, 3'd5, 1'b0, 1'b0);
      step(1'b1, 32'h0000_4108, 1'b1, 3'd1, 1'b0, 1'b0);
      step(1'b1, 32'h0000_C10C, 1'b1, 3'd2, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0001, 1'b1, 3'd0, 1'b0, 1'b0);
      step(1'b1, 32'h0080_00EF, 1'b0, 3'd5, 1'b0, 1'b0);
      step(1'b1, 32'h3000_2573, 1'b0, 3'd6, 1'b0, 1'b0);
      drain();

      // Flush with 5 held entries and overflow set
      for (int i = 0; i < 9; i++)
         step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("preflush_count", {60'd0, fifo_count_o}, 64'd5);
      chk("preflush_ovf", {63'd0, overflow_o}, 64'd1);
      step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b1, 1'b1);
      chk("flush_count", {60'd0, fifo_count_o}, 64'd0);
      chk("flush_ovf", {63'd0, overflow_o}, 64'd0);
      step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b0, 1'b0);
      drain();

      // Reset mid-drain, then first commit gets seq 0
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h0000_A103, 1'b0, 3'd1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 32'h0000_7503, 1'b0, 3'd3, 1'b0, 1'b0);
      chk("post_rst_seq", {48'd0, trace_seq_o}, 64'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
